// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_hazard_pkg;

    // Multiply/divide occupancy state
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MULT_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF  = 12;
    localparam int         MD_CNT_W        = 6;

    // Busy-cycle reload value for the selected operation (0 = multiply, 1 = divide)
    function automatic logic [MD_CNT_W-1:0] md_load_value(input logic md_op,
                                                          input int   mult_cycles,
                                                          input int   div_cycles);
        return md_op ? MD_CNT_W'(div_cycles) : MD_CNT_W'(mult_cycles);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy tracker: state bit plus load/decrement counter.
// Latency: md_busy rises the cycle after md_start and stays high for the selected cycle count.
// Backpressure: none; a new md_start while busy reloads the counter (latest operation wins).
module md_busy_counter
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_op,
    output logic md_busy
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    // Next state: a start always (re)loads; otherwise count down and drop to RUN on the last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (md_start) begin
            state_d = MD_BUSY;
            cnt_d   = md_load_value(md_op, MULT_CYCLES, DIV_CYCLES);
        end else if (state_q == MD_BUSY) begin
            if (cnt_q == MD_CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - MD_CNT_W'(1);
            end
        end
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, mult/div busy interlocks.
// Latency: all controls combinational from inputs and registered state (settle before negedge).
// Backpressure: stalls PC and IF/ID while a hazard holds; optional stats via HAZARD_STATS_EN.
module hazard_control_unit
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_ReadsHiLo,
    input  logic        ID_IsMD,
    input  logic [4:0]  EX_rt,
    input  logic        EX_MemRead,
    input  logic        BranchTaken,
    input  logic        MDStart,
    input  logic        MDOp,
`ifdef HAZARD_STATS_EN
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount,
`endif
    output logic        PCWriteEn,
    output logic        IFIDWriteEn,
    output logic        FlushIFID,
    output logic        FlushRegisters,
    output logic        MDBusy
);

    logic md_busy_raw;
    logic load_use;
    logic md_hazard;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (MDStart),
        .md_op    (MDOp),
        .md_busy  (md_busy_raw)
    );

    // Hazard decode; a taken branch squashes the ID instruction so it never stalls
    always_comb begin
        load_use  = EX_MemRead && (EX_rt != REG_ZERO) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));
        md_hazard = md_busy_raw && (ID_ReadsHiLo || ID_IsMD);
        stall     = (load_use || md_hazard) && !BranchTaken;
    end

    // Control priority: reset, then branch flush, then stall, then free-run
    always_comb begin
        PCWriteEn      = 1'b1;
        IFIDWriteEn    = 1'b1;
        FlushIFID      = 1'b0;
        FlushRegisters = 1'b0;
        if (!rst_n) begin
            PCWriteEn      = 1'b0;
            IFIDWriteEn    = 1'b0;
            FlushIFID      = 1'b1;
            FlushRegisters = 1'b1;
        end else if (BranchTaken) begin
            FlushIFID      = 1'b1;
            FlushRegisters = 1'b1;
        end else if (stall) begin
            PCWriteEn      = 1'b0;
            IFIDWriteEn    = 1'b0;
            FlushRegisters = 1'b1;
        end
    end

    // Busy is masked during reset so the interlock reads idle immediately
    assign MDBusy = md_busy_raw && rst_n;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (BranchTaken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers; nothing is counted while reset is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller that generates the flush and stall controls consumed by the negedge-clocked pipeline delay registers (`FlushRegisters` input) and by the PC and IF/ID registers. It handles three cases:
- load-use stalls;
- taken-branch flushes;
- multi-cycle multiply/divide busy interlocks, tracked by an internal state machine and cycle counter.

All outputs are combinational from current inputs and registered state. They must settle within the first half cycle so the downstream negedge registers capture them.

## Interface
Parameters:
- MULT_CYCLES, 4, busy cycles for multiply; legal range 1..63
- DIV_CYCLES, 12, busy cycles for divide; legal range 1..63

Ports:
- clk  input  1  system clock; state updates on posedge
- rst_n  input  1  synchronous, active-low reset
- ID_rs  input  5  rs field of the instruction in ID
- ID_rt  input  5  rt field of the instruction in ID
- ID_ReadsHiLo  input  1  ID instruction is MFHI/MFLO
- ID_IsMD  input  1  ID instruction is MULT/MULTU/DIV/DIVU
- EX_rt  input  5  destination rt of the instruction in EX
- EX_MemRead  input  1  EX instruction is a load
- BranchTaken  input  1  branch/jump in EX resolved taken
- MDStart  input  1  multiply/divide issued in EX this cycle
- MDOp  input  1  0 = multiply, 1 = divide (valid with MDStart)
- PCWriteEn  output  1  PC update enable
- IFIDWriteEn  output  1  IF/ID register write enable
- FlushIFID  output  1  clear the IF/ID register
- FlushRegisters  output  1  bubble into the ID/EX delay registers
- MDBusy  output  1  multiply/divide unit occupied

## Operation
- States: RUN and MD_BUSY. The counter is 6 bits, unsigned.
- **Reset** (rst_n == 0 at posedge):
  - state ← RUN, counter ← 0.
  - While rst_n is low, outputs are PCWriteEn = 0, IFIDWriteEn = 0, FlushIFID = 1, FlushRegisters = 1, MDBusy = 0.
  - Reset mid-MD_BUSY abandons the operation.
- **Load-use hazard:** `LU = EX_MemRead && EX_rt != 0 && (EX_rt == ID_rs || EX_rt == ID_rt)`.
- **MD hazard:** `MH = (state == MD_BUSY) && (ID_ReadsHiLo || ID_IsMD)`.
- **Priority 1, BranchTaken:**
  - FlushIFID = 1, FlushRegisters = 1, PCWriteEn = 1, IFIDWriteEn = 1.
  - LU and MH are ignored that cycle, because the stalled ID instruction is being squashed.
- **Priority 2, LU or MH:** PCWriteEn = 0, IFIDWriteEn = 0, FlushRegisters = 1, FlushIFID = 0.
- **Otherwise:** PCWriteEn = 1, IFIDWriteEn = 1, both flushes 0.
- **Transitions:**
  - RUN → MD_BUSY on MDStart; counter ← MDOp ? DIV_CYCLES : MULT_CYCLES.
  - In MD_BUSY, counter decrements each cycle. When counter == 1, next state is RUN and counter ← 0.
  - MDStart while in MD_BUSY reloads the counter from MDOp and stays in MD_BUSY (latest operation wins).
  - MDStart is accepted even when BranchTaken is asserted the same cycle.
- MDBusy = (state == MD_BUSY).

## Timing
- State and counter update on posedge clk. Outputs are valid before the following negedge.
- MDStart sampled at posedge k → MDBusy is high for exactly N cycles (k+1 .. k+N), with N the selected cycle count.
- The first cycle in which an MFHI/MFLO in ID proceeds is k+N+1.
- A load-use stall lasts exactly one cycle: the load leaves EX, so LU drops on its own.
- The unit never asserts a stall and FlushIFID together.

## Configuration
- With `HAZARD_STATS_EN` defined, two extra outputs are present:
  - StallCount[31:0]: increments at each posedge where stall (LU or MH, without BranchTaken) is asserted.
  - FlushCount[31:0]: increments at each posedge where BranchTaken is asserted.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not counted while rst_n is low.
- Without the macro, both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `mips_hazard_pkg` holds:
  - state encodings (RUN = 1'b0, MD_BUSY = 1'b1);
  - REG_ZERO = 5'd0;
  - defaults MULT_CYCLES_DEF = 4 and DIV_CYCLES_DEF = 12;
  - counter width constant MD_CNT_W = 6.
- One sub-module, `md_busy_counter`: load/decrement counter plus state bit, producing MDBusy. Hazard decode and priority logic stay in the top module.

## Test plan
- **Load-use:** EX_MemRead = 1, EX_rt = 8, ID_rs = 8 → one cycle of PCWriteEn = 0, IFIDWriteEn = 0, FlushRegisters = 1. Repeating with EX_rt = 0 → no stall.
- **Multiply interlock:** MDStart = 1, MDOp = 0, then ID_ReadsHiLo = 1 held → MDBusy high for 4 cycles with stall each cycle; the 5th cycle has PCWriteEn = 1.
- **Divide reload:** MDStart = 1, MDOp = 1, then MDStart with MDOp = 0 two cycles later → MDBusy high for 2 + 4 cycles total.
- **Priority:** BranchTaken = 1 together with LU true → FlushIFID = 1, FlushRegisters = 1, PCWriteEn = 1.
- **Reset mid-operation:** rst_n = 0 in the 3rd cycle of a divide → MDBusy = 0 next cycle, both flushes high while reset is held, RUN afterwards.
- **Statistics** (HAZARD_STATS_EN): 3 load-use stalls + 2 branches → StallCount = 3, FlushCount = 2.
